gcn_operand_server: RTL and testbench
=====================================

# gcn_operand_server

Memory-side responder for the GCN accelerator. It holds the weight matrix, feature matrix and COO adjacency stream, and is filled over a serial load port. Once full, it pulses `start` to the GCN core and answers the core's `read_address`/`enable_read` and `coo_address` requests with `data_in` and `coo_in`. It is the array the core reads from: bench model in simulation, on-chip operand store in the integrated design.

## Interface
- `FEATURE_ROWS`, 6, nodes (feature-matrix rows)
- `FEATURE_COLS`, 96, features per node (equals `WEIGHT_ROWS`)
- `WEIGHT_ROWS`, 96, weight-matrix rows (vector length returned per read)
- `WEIGHT_COLS`, 3, weight-matrix columns
- `DATA_WIDTH`, 5, element width of FM and WM entries
- `ADDRESS_WIDTH`, 13, read-address width
- `FM_BASE`, 512, read address of feature row 0
- `COO_NUM_OF_COLS`, 6, number of COO edges
- `COO_BW`, $clog2(`COO_NUM_OF_COLS`), COO index width
- `LOAD_WIDTH`, 8, load-data width; must be ≥ max(`DATA_WIDTH`, 2·`COO_BW`)
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high reset
- `load_start`  in  1  begin (re)fill; ignored unless state is IDLE or SERVE
- `load_valid`  in  1  load beat valid
- `load_data`  in  `LOAD_WIDTH`  load beat payload
- `load_ready`  out  1  beat accepted when `load_valid && load_ready`
- `start`  out  1  one-cycle pulse to the GCN core when the fill completes
- `enable_read`  in  1  operand read request from the core
- `read_address`  in  `ADDRESS_WIDTH`  operand read address
- `data_in`  out  `DATA_WIDTH` × `WEIGHT_ROWS` (unpacked `[0:WEIGHT_ROWS-1]`)  operand vector to the core
- `coo_address`  in  `COO_BW`  COO column index
- `coo_in`  out  `COO_BW` × 2 (unpacked `[0:1]`)  `[0]` = source row, `[1]` = destination row
- `rd_err`  out  1  sticky: out-of-range address or read outside SERVE

## Operation
- **States:** IDLE, FILL, SERVE.
- **IDLE → FILL** on `load_start`. Any `load_start` also clears the beat counter and `rd_err`.
- **SERVE → FILL** on `load_start` (reload).
- **FILL → SERVE** when the last beat is accepted.
- **Load ready:** `load_ready` = 1 only in FILL.
- **Beat count:** TOTAL = `WEIGHT_COLS`·`WEIGHT_ROWS` + `FEATURE_ROWS`·`FEATURE_COLS` + `COO_NUM_OF_COLS`. Default is 870, so the counter is 10 bits.
- **Fixed beat order:**
  - WM column-major: beat c·`WEIGHT_ROWS`+k → W[k][c].
  - FM row-major: beat 288 + r·`FEATURE_COLS`+k → F[r][k].
  - COO: beat 864+j → column j. `load_data[2·COO_BW-1:COO_BW]` = row0, `load_data[COO_BW-1:0]` = row1.
  - For FM/WM beats, only `load_data[DATA_WIDTH-1:0]` is stored.
- **Start pulse:** `start` = 1 in the cycle after the last beat is accepted (the first SERVE cycle), for exactly one cycle.
- **Read decode (SERVE):**
  - Address c < `WEIGHT_COLS` → W column c.
  - `FM_BASE` ≤ a < `FM_BASE`+`FEATURE_ROWS` → F row a−`FM_BASE`.
  - Any other address → all-zero vector and `rd_err` set.
- **Reads outside SERVE:** `enable_read` in IDLE or FILL → zero vector and `rd_err` set.
- **COO read:** `coo_in` is combinational from `coo_address`.
  - Outside SERVE, or `coo_address` ≥ `COO_NUM_OF_COLS` → {0, 0}.
  - The out-of-range `coo_address` case does not set `rd_err`.
- **Storage:** not reset. Contents survive reset and `load_start`, and are overwritten beat by beat during the next fill.

## Timing
- **Reset values:** state = IDLE; `load_ready`, `start`, `rd_err` = 0; `data_in` all zeros. `coo_in` = {0, 0} because the state is not SERVE.
- **Reset mid-fill:** returns to IDLE; partial data is retained but unusable until a full refill.
- **Read latency:** 1 cycle. `data_in` updates on the clock edge after `enable_read` is sampled high.
- **Read hold:** with `enable_read` low, `data_in` holds its last value.
- **Load throughput:** one beat per cycle at full rate; `load_valid` gaps stall the counter.
- **`load_start` during FILL:** ignored; the counter is not cleared.
- **`load_start` coincident with a beat in SERVE:** the beat is not accepted (`load_ready` = 0 that cycle). FILL begins next cycle with counter 0.
- **`enable_read` coincident with the last load beat:** the read is not in SERVE, so it returns zeros and sets `rd_err`.
- **`enable_read` on the `start` cycle:** valid; the state is already SERVE.

## Test plan
- **Reset:** assert `reset` mid-fill at beat 400 → next cycle state IDLE, `load_ready` = 0, `data_in` = 0, `start` never pulses.
- **Full fill with W[k][c] = (k+c) mod 32 and F[r][k] = (r·k) mod 32:** `start` pulses once, in the cycle after beat 869 is accepted. `read_address` = 1 → next cycle `data_in[5]` = 6. `read_address` = 514 → `data_in[7]` = 14.
- **COO loaded with beat 864+j = {j, (j+1) mod 6}:** in SERVE, `coo_address` = 5 → `coo_in[0]` = 5, `coo_in[1]` = 0 in the same cycle. `coo_address` = 7 → {0, 0}.
- **Out-of-range reads in SERVE:** `read_address` = 3 → zeros, `rd_err` = 1 and stays 1. `read_address` = 518 → zeros. A subsequent `load_start` clears `rd_err`.
- **Throttled load:** `load_valid` toggled every other cycle → `start` at cycle ≈ 1740. Data identical to the full-rate fill.
- **Reload from SERVE with all elements = 31:** after the second `start`, every read returns 31. Reads during the refill return zeros and set `rd_err`.

Source files
------------

// File: rtl/gcn_operand_server.sv
// gcn_operand_server: serially filled operand store that pulses start and serves
// weight columns, feature rows and COO edges to the GCN core.
module gcn_operand_server #(
  parameter int FEATURE_ROWS    = 6,
  parameter int FEATURE_COLS    = 96,
  parameter int WEIGHT_ROWS     = 96,
  parameter int WEIGHT_COLS     = 3,
  parameter int DATA_WIDTH      = 5,
  parameter int ADDRESS_WIDTH   = 13,
  parameter int FM_BASE         = 512,
  parameter int COO_NUM_OF_COLS = 6,
  parameter int COO_BW          = $clog2(COO_NUM_OF_COLS),
  parameter int LOAD_WIDTH      = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_start,
  input  logic                     load_valid,
  input  logic [LOAD_WIDTH-1:0]    load_data,
  output logic                     load_ready,
  output logic                     start,
  input  logic                     enable_read,
  input  logic [ADDRESS_WIDTH-1:0] read_address,
  output logic [DATA_WIDTH-1:0]    data_in [0:WEIGHT_ROWS-1],
  input  logic [COO_BW-1:0]        coo_address,
  output logic [COO_BW-1:0]        coo_in [0:1],
  output logic                     rd_err
);
  localparam int WM_SIZE = WEIGHT_COLS * WEIGHT_ROWS;
  localparam int OPS     = WM_SIZE + FEATURE_ROWS * FEATURE_COLS;
  localparam int TOTAL   = OPS + COO_NUM_OF_COLS;
  localparam int CW      = $clog2(TOTAL);
  localparam logic [CW-1:0] LAST  = CW'(TOTAL - 1);
  localparam logic [CW-1:0] OPS_C = CW'(OPS);
  typedef enum logic [1:0] {IDLE, FILL, SERVE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  // Operands are stored in beat order, so the beat counter is the write address.
  logic [DATA_WIDTH-1:0] mem [0:OPS-1];
  logic [COO_BW-1:0] coo_src [0:COO_NUM_OF_COLS-1];
  logic [COO_BW-1:0] coo_dst [0:COO_NUM_OF_COLS-1];
  logic [DATA_WIDTH-1:0] rd_vec [0:WEIGHT_ROWS-1];
  logic rd_hit, accept, serve, coo_ok;
  assign serve      = state == SERVE;
  assign load_ready = state == FILL;
  assign accept     = load_valid && load_ready;
  assign coo_ok     = serve && ({1'b0, coo_address} < (COO_BW + 1)'(COO_NUM_OF_COLS));
  assign coo_in[0]  = coo_ok ? coo_src[coo_address] : '0;
  assign coo_in[1]  = coo_ok ? coo_dst[coo_address] : '0;
  always_ff @(posedge clk) begin
    if (accept && cnt < OPS_C) mem[cnt] <= load_data[DATA_WIDTH-1:0];
    for (int j = 0; j < COO_NUM_OF_COLS; j++)
      if (accept && cnt == CW'(OPS + j)) begin
        coo_src[j] <= load_data[2*COO_BW-1:COO_BW];
        coo_dst[j] <= load_data[COO_BW-1:0];
      end
  end
  always_comb begin
    rd_hit = 1'b0;
    for (int k = 0; k < WEIGHT_ROWS; k++) rd_vec[k] = '0;
    for (int c = 0; c < WEIGHT_COLS; c++)
      if (read_address == ADDRESS_WIDTH'(c)) begin
        rd_hit = 1'b1;
        for (int k = 0; k < WEIGHT_ROWS; k++) rd_vec[k] = mem[c*WEIGHT_ROWS + k];
      end
    for (int r = 0; r < FEATURE_ROWS; r++)
      if (read_address == ADDRESS_WIDTH'(FM_BASE + r)) begin
        rd_hit = 1'b1;
        for (int k = 0; k < FEATURE_COLS; k++) rd_vec[k] = mem[WM_SIZE + r*FEATURE_COLS + k];
      end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      start  <= 1'b0;
      rd_err <= 1'b0;
      for (int k = 0; k < WEIGHT_ROWS; k++) data_in[k] <= '0;
    end else begin
      start <= 1'b0;
      if (load_start && state != FILL) begin
        state  <= FILL;
        cnt    <= '0;
        rd_err <= 1'b0;
      end else if (accept) begin
        cnt <= cnt + 1'b1;
        if (cnt == LAST) begin
          state <= SERVE;
          start <= 1'b1;
        end
      end
      if (enable_read) begin
        for (int k = 0; k < WEIGHT_ROWS; k++) data_in[k] <= (serve && rd_hit) ? rd_vec[k] : '0;
        if (!(serve && rd_hit)) rd_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_gcn_operand_server.sv
// tb_gcn_operand_server: randomized reads against a matrix-level reference model,
// with a queue-based scoreboard popped by an independent read monitor.
module tb_gcn_operand_server;
  localparam int FR = 6, FC = 96, WR = 96, WC = 3, DW = 5, AW = 13, FMB = 512, CN = 6, CB = 3, LW = 8;
  localparam int OPS = WC*WR + FR*FC;
  localparam int TOTAL = OPS + CN;
  localparam int VW = DW*WR;
  typedef logic [VW-1:0] vec_t;
  typedef struct {vec_t v; logic e;} rsp_t;
  logic clk = 0, reset = 1, load_start = 0, load_valid = 0, enable_read = 0;
  logic load_ready, start, rd_err;
  logic [LW-1:0] load_data = '0;
  logic [AW-1:0] read_address = '0;
  logic [CB-1:0] coo_address = 3'd5;
  logic [DW-1:0] data_in [0:WR-1];
  logic [CB-1:0] coo_in [0:1];
  int compared = 0, mismatched = 0, edges = 0, starts = 0;
  int start_edge = -1, last_edge = -2, ls_edge = 0;
  rsp_t q[$];
  int w [WR][WC];
  int f [FR][FC];
  int c_src [CN];
  int c_dst [CN];
  bit serve = 0;
  logic exp_err = 0, rd_pend = 0;
  vec_t last = '0;

  gcn_operand_server dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_ready(load_ready), .start(start),
    .enable_read(enable_read), .read_address(read_address), .data_in(data_in),
    .coo_address(coo_address), .coo_in(coo_in), .rd_err(rd_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges++;
  always @(posedge clk or posedge reset) rd_pend <= reset ? 1'b0 : enable_read;

  function automatic vec_t packv();
    vec_t p;
    for (int k = 0; k < WR; k++) p[k*DW +: DW] = data_in[k];
    return p;
  endfunction

  task automatic check(string n, vec_t a, vec_t e);
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (start) begin
      starts++;
      start_edge = edges;
    end
    if (reset) last = '0;
    else if (rd_pend) begin
      if (q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL read_queue: DUT read with no expected entry");
      end else begin
        rsp_t r;
        r = q.pop_front();
        check("read_vec", packv(), r.v);
        check("rd_err", VW'(rd_err), VW'(r.e));
        last = r.v;
      end
    end else check("hold", packv(), last);
  end

  function automatic rsp_t model_rd(int a);
    rsp_t r;
    r.v = '0;
    r.e = 1'b1;
    if (serve && a < WC) begin
      r.e = 1'b0;
      for (int k = 0; k < WR; k++) r.v[k*DW +: DW] = DW'(w[k][a]);
    end else if (serve && a >= FMB && a < FMB + FR) begin
      r.e = 1'b0;
      for (int k = 0; k < FC; k++) r.v[k*DW +: DW] = DW'(f[a-FMB][k]);
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rd(int a);
    rsp_t r;
    r = model_rd(a);
    exp_err = exp_err | r.e;
    r.e = exp_err;
    q.push_back(r);
    enable_read = 1;
    read_address = AW'(a);
  endtask

  task automatic rd(int a);
    push_rd(a);
    tick();
    enable_read = 0;
  endtask

  task automatic fill(int mode, bit thr, int stop, bit mix);
    int c, k, r, j, val, s, t;
    logic [LW-1:0] d;
    load_start = 1;
    load_valid = 1;
    load_data = '1;
    tick();
    load_start = 0;
    load_valid = 0;
    serve = 0;
    exp_err = 0;
    ls_edge = edges;
    check("rd_err_cleared", VW'(rd_err), '0);
    check("load_ready_fill", VW'(load_ready), VW'(1));
    for (int b = 0; b < TOTAL && b != stop; b++) begin
      if (thr) begin
        load_valid = 0;
        tick();
      end
      if (b < WC*WR) begin
        c = b / WR; k = b % WR;
        val = mode ? 31 : (k + c) % 32;
        w[k][c] = val;
        d = {3'($urandom), 5'(val)};
      end else if (b < OPS) begin
        r = (b - WC*WR) / FC; k = (b - WC*WR) % FC;
        val = mode ? 31 : (r * k) % 32;
        f[r][k] = val;
        d = {3'($urandom), 5'(val)};
      end else begin
        j = b - OPS;
        s = mode ? 5 - j : j;
        t = mode ? j : (j + 1) % CN;
        c_src[j] = s;
        c_dst[j] = t;
        d = {2'b0, 3'(s), 3'(t)};
      end
      load_valid = 1;
      load_data = d;
      if (mix && (b % 200 == 50 || b == TOTAL - 1)) push_rd(int'($urandom_range(0, 2)));
      if (mix && b == 100) load_start = 1;
      tick();
      enable_read = 0;
      load_start = 0;
    end
    load_valid = 0;
    last_edge = edges;
    serve = stop >= TOTAL;
  endtask

  task automatic coo_check();
    for (int j = 0; j < 8; j++) begin
      coo_address = CB'(j);
      #1;
      check("coo_src", VW'(coo_in[0]), VW'(j < CN ? c_src[j] : 0));
      check("coo_dst", VW'(coo_in[1]), VW'(j < CN ? c_dst[j] : 0));
    end
  endtask

  task automatic rand_reads(int n);
    int bads [4] = '{3, 518, 511, 8191};
    for (int i = 0; i < n; i++) begin
      int p = int'($urandom_range(0, 9));
      rd(p < 3 ? p : p < 9 ? FMB + p - 3 : bads[$urandom_range(0, 3)]);
      if ($urandom_range(0, 3) == 0) tick();
    end
  endtask

  initial begin
    tick();
    tick();
    check("rst_load_ready", VW'(load_ready), '0);
    check("rst_start", VW'(start), '0);
    check("rst_rd_err", VW'(rd_err), '0);
    check("rst_data_in", packv(), '0);
    check("rst_coo", VW'({coo_in[0], coo_in[1]}), '0);
    reset = 0;
    tick();
    rd(1);
    tick();
    fill(0, 0, 400, 0);
    reset = 1;
    #1;
    check("midfill_load_ready", VW'(load_ready), '0);
    check("midfill_data_in", packv(), '0);
    tick();
    tick();
    reset = 0;
    exp_err = 0;
    tick();
    check("idle_load_ready", VW'(load_ready), '0);
    check("no_start_after_reset", VW'(starts), '0);
    fill(0, 0, TOTAL, 0);
    rd(1);
    check("w_k5_c1", VW'(data_in[5]), VW'(6));
    check("start_cycle", VW'(start_edge), VW'(last_edge));
    check("start_count1", VW'(starts), VW'(1));
    rd(514);
    check("f_r2_k7", VW'(data_in[7]), VW'(14));
    coo_check();
    rd(3);
    check("oob_rd_err", VW'(rd_err), VW'(1));
    rd(518);
    tick();
    check("rd_err_sticky", VW'(rd_err), VW'(1));
    rand_reads(150);
    fill(0, 1, TOTAL, 0);
    tick();
    check("throttle_start_cycle", VW'(start_edge), VW'(last_edge));
    check("throttle_duration", VW'(last_edge - ls_edge), VW'(2 * TOTAL));
    check("start_count2", VW'(starts), VW'(2));
    rand_reads(100);
    coo_check();
    fill(1, 0, TOTAL, 1);
    rd(int'($urandom_range(0, 2)));
    check("reload_start_cycle", VW'(start_edge), VW'(last_edge));
    check("start_count3", VW'(starts), VW'(3));
    check("rd_err_last_beat", VW'(rd_err), VW'(1));
    rand_reads(100);
    coo_check();
    tick();
    tick();
    tick();
    check("queue_drained", VW'(q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
